// File: rtl/filt_frame_ctrl.sv
// filt_frame_ctrl: frame-synchronous config, geometry tracking and
// matched-latency output select for the 3x3 filter stage.
module filt_frame_ctrl #(
  parameter int H_ACT    = 1280,
  parameter int V_ACT    = 720,
  parameter int FILT_LAT = 4
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_mode,
  input  logic        cfg_border,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [7:0]  in_data,
  input  logic [7:0]  filt_data0,
  input  logic [7:0]  filt_data1,
  input  logic [7:0]  filt_data2,
  output logic        out_vs,
  output logic        out_de,
  output logic [7:0]  out_data,
  output logic [1:0]  active_mode,
  output logic [15:0] frame_cnt,
  output logic        err_geom
);

  localparam int CW = $clog2(H_ACT + 1);
  localparam int RW = $clog2(V_ACT + 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(H_ACT);
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACT - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(V_ACT);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_ACT - 1);

  typedef enum logic {
    WAIT_VS,
    FRAME
  } state_t;

  state_t          state;
  logic            in_vs_q;
  logic            de_q;
  logic            pend_vld;
  logic [1:0]      pend_mode;
  logic            pend_border;
  logic            active_border;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;

  logic            vs_rise;
  logic            de_fall;
  logic            cfg_xfer;
  logic            border;
  logic            bypass;

  assign vs_rise   = in_vs & ~in_vs_q;
  assign de_fall   = de_q & ~in_de;
  assign cfg_ready = ~pend_vld;
  assign cfg_xfer  = cfg_valid & cfg_ready;
  assign bypass    = (active_mode == 2'd0);
  assign border    = in_de & ((col == '0) | (col == COL_LAST) |
                              (row == '0) | (row == ROW_LAST));

  // A request landing on the vs_rise cycle fills an empty slot and
  // therefore waits for the following frame edge.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vs_q       <= 1'b0;
      pend_vld      <= 1'b0;
      pend_mode     <= '0;
      pend_border   <= 1'b0;
      active_mode   <= '0;
      active_border <= 1'b0;
    end else begin
      in_vs_q <= in_vs;
      if (cfg_xfer) begin
        pend_vld    <= 1'b1;
        pend_mode   <= cfg_mode;
        pend_border <= cfg_border;
      end else if (vs_rise && pend_vld) begin
        pend_vld      <= 1'b0;
        active_mode   <= pend_mode;
        active_border <= pend_border;
      end
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_VS;
      de_q      <= 1'b0;
      col       <= '0;
      row       <= '0;
      frame_cnt <= '0;
      err_geom  <= 1'b0;
    end else begin
      de_q <= in_de;
      unique case (state)
        WAIT_VS: begin
          if (vs_rise) begin
            state     <= FRAME;
            col       <= '0;
            row       <= '0;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        FRAME: begin
          if (vs_rise) begin
            if (row != ROW_MAX) err_geom <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            row       <= '0;
            col       <= '0;
          end else if (de_fall) begin
            if (col != COL_MAX) err_geom <= 1'b1;
            if (row != ROW_MAX) row <= row + RW'(1);
            col <= '0;
          end else if (in_de && col != COL_MAX) begin
            col <= col + CW'(1);
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

  // The select is resolved on entry: fsel 0 takes the (possibly zeroed)
  // raw pixel, 1..3 take the matching filter result at the output.
  logic [7:0] pix_in;
  logic [1:0] fsel_in;

  always_comb begin
    pix_in  = '0;
    fsel_in = '0;
    unique case (1'b1)
      in_de & bypass:            pix_in  = in_data;
      in_de & ~bypass & ~border: fsel_in = active_mode;
      in_de & ~bypass & border:  pix_in  = active_border ? in_data : 8'd0;
      default:                   pix_in  = '0;
    endcase
  end

  logic [FILT_LAT-1:0] vs_sr;
  logic [FILT_LAT-1:0] de_sr;
  logic [7:0]          pix_sr  [FILT_LAT];
  logic [1:0]          fsel_sr [FILT_LAT];

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sr <= '0;
      de_sr <= '0;
      for (int i = 0; i < FILT_LAT; i++) begin
        pix_sr[i]  <= '0;
        fsel_sr[i] <= '0;
      end
    end else begin
      vs_sr[0]   <= in_vs;
      de_sr[0]   <= in_de;
      pix_sr[0]  <= pix_in;
      fsel_sr[0] <= fsel_in;
      for (int i = 1; i < FILT_LAT; i++) begin
        vs_sr[i]   <= vs_sr[i-1];
        de_sr[i]   <= de_sr[i-1];
        pix_sr[i]  <= pix_sr[i-1];
        fsel_sr[i] <= fsel_sr[i-1];
      end
    end
  end

  assign out_vs = vs_sr[FILT_LAT-1];
  assign out_de = de_sr[FILT_LAT-1];

  always_comb begin
    unique case (fsel_sr[FILT_LAT-1])
      2'd1:    out_data = filt_data0;
      2'd2:    out_data = filt_data1;
      2'd3:    out_data = filt_data2;
      default: out_data = pix_sr[FILT_LAT-1];
    endcase
  end

endmodule

// File: tb/tb_filt_frame_ctrl.sv
// tb_filt_frame_ctrl: directed frame sequence with random pixel and
// filter data, checked against a per-pixel reference model.
module tb_filt_frame_ctrl;

  localparam int H = 8;
  localparam int V = 4;
  localparam int L = 4;

  logic        video_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_mode = 2'd0;
  logic        cfg_border = 1'b0;
  logic        in_vs = 1'b0;
  logic        in_de = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic [7:0]  filt_data0 = 8'd0;
  logic [7:0]  filt_data1 = 8'd0;
  logic [7:0]  filt_data2 = 8'd0;
  logic        out_vs;
  logic        out_de;
  logic [7:0]  out_data;
  logic [1:0]  active_mode;
  logic [15:0] frame_cnt;
  logic        err_geom;

  int checks = 0;
  int errors = 0;

  always #5 video_clk = ~video_clk;

  filt_frame_ctrl #(.H_ACT(H), .V_ACT(V), .FILT_LAT(L)) dut (
    .video_clk  (video_clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_border (cfg_border),
    .in_vs      (in_vs),
    .in_de      (in_de),
    .in_data    (in_data),
    .filt_data0 (filt_data0),
    .filt_data1 (filt_data1),
    .filt_data2 (filt_data2),
    .out_vs     (out_vs),
    .out_de     (out_de),
    .out_data   (out_data),
    .active_mode(active_mode),
    .frame_cnt  (frame_cnt),
    .err_geom   (err_geom)
  );

  // Per-cycle input history since the last reset.
  int         t;
  logic       hvs  [4096];
  logic       hde  [4096];
  logic [7:0] hexp [4096];
  logic [7:0] hf0  [4096];
  logic [7:0] hf1  [4096];
  logic [7:0] hf2  [4096];

  logic [1:0] m_mode;
  logic       m_border;
  logic       m_pend;
  logic [1:0] p_mode;
  logic       p_border;
  logic       m_vs;
  int         m_frames;
  logic       m_inframe;
  logic       exp_err;
  logic       pend_row_err;

  int         req_line   [2];
  logic [1:0] req_mode   [2];
  logic       req_border [2];

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_mode = 2'd0;
    m_border = 1'b0;
    m_pend = 1'b0;
    p_mode = 2'd0;
    p_border = 1'b0;
    m_vs = 1'b0;
    m_frames = 0;
    m_inframe = 1'b0;
    exp_err = 1'b0;
    pend_row_err = 1'b0;
    req_line[0] = -1;
    req_line[1] = -1;
  endtask

  task automatic check_reset_state();
    check("rst_out_vs", 16'(out_vs), 16'd0);
    check("rst_out_de", 16'(out_de), 16'd0);
    check("rst_out_data", 16'(out_data), 16'd0);
    check("rst_active_mode", 16'(active_mode), 16'd0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_err_geom", 16'(err_geom), 16'd0);
    check("rst_cfg_ready", 16'(cfg_ready), 16'd1);
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cyc(input logic vs, input logic de, input logic [7:0] d,
                     input int r, input int c);
    logic [7:0] f0, f1, f2, e;
    logic       bord, rise;
    logic       evs, ede;
    logic [7:0] edata;
    f0 = 8'($urandom);
    f1 = 8'($urandom);
    f2 = 8'($urandom);
    in_vs = vs;
    in_de = de;
    in_data = d;
    if (t >= L) begin
      filt_data0 = hf0[t-L];
      filt_data1 = hf1[t-L];
      filt_data2 = hf2[t-L];
    end else begin
      filt_data0 = 8'($urandom);
      filt_data1 = 8'($urandom);
      filt_data2 = 8'($urandom);
    end
    bord = de && (c == 0 || c == H - 1 || r == 0 || r == V - 1);
    if (!de) e = 8'd0;
    else if (m_mode == 2'd0) e = d;
    else if (!bord) e = (m_mode == 2'd1) ? f0 : (m_mode == 2'd2) ? f1 : f2;
    else e = m_border ? d : 8'd0;
    hvs[t] = vs;
    hde[t] = de;
    hexp[t] = e;
    hf0[t] = f0;
    hf1[t] = f1;
    hf2[t] = f2;
    evs = 1'b0;
    ede = 1'b0;
    edata = 8'd0;
    if (t >= L) begin
      evs = hvs[t-L];
      ede = hde[t-L];
      edata = hexp[t-L];
    end
    @(negedge video_clk);
    check("out_vs", 16'(out_vs), 16'(evs));
    check("out_de", 16'(out_de), 16'(ede));
    check("out_data", 16'(out_data), 16'(edata));
    check("cfg_ready", 16'(cfg_ready), 16'(!m_pend));
    check("active_mode", 16'(active_mode), 16'(m_mode));
    check("frame_cnt", frame_cnt, 16'(m_frames));
    @(posedge video_clk);
    #1;
    rise = vs && !m_vs;
    m_vs = vs;
    if (cfg_valid && !m_pend) begin
      m_pend = 1'b1;
      p_mode = cfg_mode;
      p_border = cfg_border;
    end else if (rise && m_pend) begin
      m_pend = 1'b0;
      m_mode = p_mode;
      m_border = p_border;
    end
    if (rise) m_frames++;
    t++;
  endtask

  // Line -2 means the vs_rise cycle; otherwise first pixel of line r.
  task automatic set_req(input int r);
    cfg_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (req_line[k] == r) begin
        cfg_valid = 1'b1;
        cfg_mode = req_mode[k];
        cfg_border = req_border[k];
      end
    end
  endtask

  task automatic frame(input int nlines, input int short_line,
                       input bit pat);
    int len;
    logic [7:0] d;
    if (m_inframe && pend_row_err) exp_err = 1'b1;
    pend_row_err = 1'b0;
    set_req(-2);
    cyc(1'b1, 1'b0, 8'd0, 0, 0);
    cfg_valid = 1'b0;
    cyc(1'b1, 1'b0, 8'd0, 0, 0);
    cyc(1'b0, 1'b0, 8'd0, 0, 0);
    cyc(1'b0, 1'b0, 8'd0, 0, 0);
    m_inframe = 1'b1;
    check("err_geom_vs", 16'(err_geom), 16'(exp_err));
    for (int r = 0; r < nlines; r++) begin
      len = (r == short_line) ? H - 1 : H;
      for (int c = 0; c < len; c++) begin
        if (c == 0) set_req(r);
        d = pat ? 8'(c + 16 * r) : 8'($urandom);
        cyc(1'b0, 1'b1, d, r, c);
        cfg_valid = 1'b0;
      end
      cyc(1'b0, 1'b0, 8'd0, 0, 0);
      cyc(1'b0, 1'b0, 8'd0, 0, 0);
      if (len != H) exp_err = 1'b1;
      check("err_geom_line", 16'(err_geom), 16'(exp_err));
    end
    if (nlines != V) pend_row_err = 1'b1;
    req_line[0] = -1;
    req_line[1] = -1;
  endtask

  initial begin
    model_reset();
    #1;
    check_reset_state();
    @(posedge video_clk);
    @(posedge video_clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 8'd0, 0, 0);

    // A, B: pass-through; B requests mode 1 / zero border mid-frame.
    frame(V, -1, 1'b1);
    req_line[0] = 2; req_mode[0] = 2'd1; req_border[0] = 1'b0;
    frame(V, -1, 1'b1);
    // C: mode 1 active; mode 3 / raw border requested, a second
    // request while the slot is full is dropped.
    req_line[0] = 1; req_mode[0] = 2'd3; req_border[0] = 1'b1;
    req_line[1] = 2; req_mode[1] = 2'd2; req_border[1] = 1'b0;
    frame(V, -1, 1'b0);
    // D: mode 3.  E: request lands on the vs_rise cycle itself.
    frame(V, -1, 1'b0);
    req_line[0] = -2; req_mode[0] = 2'd2; req_border[0] = 1'b1;
    frame(V, -1, 1'b0);
    // F: mode 2 with a 7-pixel line; G, H well formed.
    frame(V, 1, 1'b0);
    frame(V, -1, 1'b0);
    frame(V, -1, 1'b0);

    // I: reset part-way through line 1 with mode 2 active.
    cyc(1'b1, 1'b0, 8'd0, 0, 0);
    cyc(1'b1, 1'b0, 8'd0, 0, 0);
    cyc(1'b0, 1'b0, 8'd0, 0, 0);
    cyc(1'b0, 1'b0, 8'd0, 0, 0);
    for (int c = 0; c < H; c++) cyc(1'b0, 1'b1, 8'($urandom), 0, c);
    cyc(1'b0, 1'b0, 8'd0, 0, 0);
    cyc(1'b0, 1'b0, 8'd0, 0, 0);
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b1, 8'($urandom), 1, c);
    check("mode_before_rst", 16'(active_mode), 16'd2);
    #2;
    rst_n = 1'b0;
    in_de = 1'b0;
    in_vs = 1'b0;
    cfg_valid = 1'b0;
    #1;
    check_reset_state();
    @(posedge video_clk);
    @(posedge video_clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (6) cyc(1'b0, 1'b0, 8'd0, 0, 0);

    // J: counts from 1.  K: 3 lines.  L flags it, M keeps it.
    frame(V, -1, 1'b1);
    frame(V - 1, -1, 1'b0);
    frame(V, -1, 1'b0);
    frame(V, -1, 1'b0);
    check("err_geom_sticky", 16'(err_geom), 16'd1);
    check("frame_cnt_end", frame_cnt, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
